// File: rtl/arm_risc_core_if.sv
// Control-word and debug bus of the 8-bit RISC datapath.
// The sequencer (master) drives a pre-decoded control word; the core (slave) exports its state.
interface arm_risc_core_if;
  logic       eint;
  logic [7:0] Literal;
  logic [5:0] Addr;
  logic [7:0] datain;
  logic       wr_en;
  logic [5:0] calu;
  logic [1:0] cpc;
  logic [1:0] csrc;
  logic [2:0] cmsrc;
  logic       cal;
  logic       ret;
  logic       pop;
  logic       push;
  logic [7:0] ambain;

  logic [7:0] dataout;
  logic [7:0] R0, R1, R2, R3, R4, R5, R6;
  logic [7:0] PC;
  logic [7:0] muxout;
  logic [7:0] CEE;
  logic       CEENZ;
  logic [7:0] LNK;
  logic [7:0] stack;

  modport slave (
    input  eint, Literal, Addr, datain, wr_en, calu, cpc, csrc, cmsrc,
           cal, ret, pop, push, ambain,
    output dataout, R0, R1, R2, R3, R4, R5, R6, PC, muxout, CEE, CEENZ, LNK, stack
  );

  modport master (
    output eint, Literal, Addr, datain, wr_en, calu, cpc, csrc, cmsrc,
           cal, ret, pop, push, ambain,
    input  dataout, R0, R1, R2, R3, R4, R5, R6, PC, muxout, CEE, CEENZ, LNK, stack
  );
endinterface

// File: rtl/arm_risc_core.sv
// Single-cycle 8-bit RISC datapath: 64x8 register file, PC, link register, hardware stack,
// ALU and compare-skip, executing one externally decoded control word per clock.
module arm_risc_core #(
  parameter int STACK_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  arm_risc_core_if.slave  bus
);

  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [7:0]      regs [64];
  logic [7:0]      stk  [STACK_DEPTH];
  logic [SP_W-1:0] sp;
  logic [7:0]      pc;
  logic [7:0]      lnk;

  logic [SP_W-1:0]  sp_dec;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;
  logic             stack_empty;
  logic             stack_full;
  logic [7:0]       tos;
  logic [7:0]       alu_res;
  logic [7:0]       mux_data;
  logic [7:0]       cee;
  logic [7:0]       pc_inc;
  logic [7:0]       pc_next;
  logic             stk_op;
  logic             do_pop;
  logic             do_push;
  logic             reg_we;

  function automatic logic [7:0] alu_op(input logic [5:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] r;
    case (op)
      6'd0:    r = a;
      6'd1:    r = a + b;
      6'd2:    r = a - b;
      6'd3:    r = a & b;
      6'd4:    r = a | b;
      6'd5:    r = a ^ b;
      6'd6:    r = ~a;
      6'd7:    r = {a[6:0], 1'b0};
      6'd8:    r = {1'b0, a[7:1]};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Stack pointer counts occupied entries; the top lives one below it.
  assign sp_dec      = sp - SP_W'(1);
  assign top_idx     = sp_dec[IDX_W-1:0];
  assign push_idx    = sp[IDX_W-1:0];
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign tos         = stack_empty ? 8'h00 : stk[top_idx];

  assign alu_res = alu_op(bus.calu, regs[1], regs[2]);
  assign cee     = regs[0] ^ bus.Literal;
  assign pc_inc  = pc + 8'd1;

  always_comb begin
    mux_data = 8'h00;
    if (bus.pop) begin
      mux_data = tos;
    end else begin
      case (bus.csrc)
        2'd0:    mux_data = bus.datain;
        2'd1:    mux_data = bus.Literal;
        2'd2:    mux_data = regs[{3'b000, bus.cmsrc}];
        default: mux_data = alu_res;
      endcase
    end
  end

  // Interrupt, call and return pre-empt any stack operation; pop beats push.
  assign stk_op  = ~bus.eint & ~bus.cal & ~bus.ret & (bus.push | bus.pop);
  assign do_pop  = stk_op & bus.pop;
  assign do_push = stk_op & bus.push & ~bus.pop;
  assign reg_we  = bus.wr_en & ~bus.eint & ~bus.cal & ~bus.ret & ~(bus.push & ~bus.pop)
                 & ((bus.cpc != 2'd0) | bus.pop);

  always_comb begin
    pc_next = pc;
    if (bus.eint) begin
      pc_next = bus.ambain;
    end else if (bus.cal) begin
      pc_next = bus.Literal;
    end else if (bus.ret) begin
      pc_next = lnk;
    end else if (bus.push || bus.pop) begin
      pc_next = pc_inc;
    end else begin
      case (bus.cpc)
        2'd0:    pc_next = bus.Literal;
        2'd1:    pc_next = pc_inc;
        2'd2:    pc_next = (|cee) ? pc + 8'd2 : pc_inc;
        default: pc_next = pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
      for (int j = 0; j < STACK_DEPTH; j++) stk[j] <= 8'h00;
      pc  <= 8'h00;
      lnk <= 8'h00;
      sp  <= '0;
    end else begin
      pc <= pc_next;
      if (bus.eint || bus.cal) lnk <= pc_inc;
      if (reg_we) regs[bus.Addr] <= mux_data;
      if (do_push && !stack_full) begin
        stk[push_idx] <= regs[bus.Addr];
        sp            <= sp + SP_W'(1);
      end
      if (do_pop && !stack_empty) sp <= sp_dec;
    end
  end

  assign bus.dataout = regs[bus.Addr];
  assign bus.R0      = regs[0];
  assign bus.R1      = regs[1];
  assign bus.R2      = regs[2];
  assign bus.R3      = regs[3];
  assign bus.R4      = regs[4];
  assign bus.R5      = regs[5];
  assign bus.R6      = regs[6];
  assign bus.PC      = pc;
  assign bus.muxout  = mux_data;
  assign bus.CEE     = cee;
  assign bus.CEENZ   = |cee;
  assign bus.LNK     = lnk;
  assign bus.stack   = tos;

endmodule

// File: tb/tb_arm_risc_core.sv
// Bench for arm_risc_core: directed programs plus random control words against a behavioural model.
module tb_arm_risc_core;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  arm_risc_core_if bus ();

  arm_risc_core #(.STACK_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0] m_reg [64];
  logic [7:0] m_stk [$];
  logic [7:0] m_pc;
  logic [7:0] m_lnk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = a;
      1: r = a + b;
      2: r = a - b;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = 255 - a;
      7: r = a * 2;
      8: r = a / 2;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  function automatic logic [7:0] m_top();
    return (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 8'h00;
  endfunction

  function automatic logic [7:0] m_mux();
    if (bus.pop) return m_top();
    case (bus.csrc)
      2'd0: return bus.datain;
      2'd1: return bus.Literal;
      2'd2: return m_reg[int'(bus.cmsrc)];
      default: return m_alu(int'(bus.calu), int'(m_reg[1]), int'(m_reg[2]));
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
    m_stk.delete();
    m_pc  = 8'h00;
    m_lnk = 8'h00;
  endtask

  task automatic m_exec();
    logic [7:0] mux;
    logic [7:0] nxt;
    mux = m_mux();
    nxt = m_pc + 8'd1;
    if (bus.eint) begin
      m_lnk = nxt;
      m_pc  = bus.ambain;
    end else if (bus.cal) begin
      m_lnk = nxt;
      m_pc  = bus.Literal;
    end else if (bus.ret) begin
      m_pc = m_lnk;
    end else if (bus.pop) begin
      m_pc = nxt;
      if (m_stk.size() > 0) void'(m_stk.pop_back());
      if (bus.wr_en) m_reg[bus.Addr] = mux;
    end else if (bus.push) begin
      m_pc = nxt;
      if (m_stk.size() < 8) m_stk.push_back(m_reg[bus.Addr]);
    end else begin
      if (bus.cpc == 2'd0) m_pc = bus.Literal;
      else if (bus.cpc == 2'd1) m_pc = nxt;
      else if (bus.cpc == 2'd2) m_pc = (m_reg[0] != bus.Literal) ? m_pc + 8'd2 : nxt;
      if (bus.wr_en && bus.cpc != 2'd0) m_reg[bus.Addr] = mux;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".R0"}, bus.R0, m_reg[0]);
    check({tag, ".R1"}, bus.R1, m_reg[1]);
    check({tag, ".R2"}, bus.R2, m_reg[2]);
    check({tag, ".R3"}, bus.R3, m_reg[3]);
    check({tag, ".R4"}, bus.R4, m_reg[4]);
    check({tag, ".R5"}, bus.R5, m_reg[5]);
    check({tag, ".R6"}, bus.R6, m_reg[6]);
    check({tag, ".PC"}, bus.PC, m_pc);
    check({tag, ".LNK"}, bus.LNK, m_lnk);
    check({tag, ".stack"}, bus.stack, m_top());
  endtask

  task automatic nop();
    bus.eint = 1'b0; bus.Literal = 8'h00; bus.Addr = 6'd0; bus.datain = 8'h00;
    bus.wr_en = 1'b0; bus.calu = 6'd0; bus.cpc = 2'd3; bus.csrc = 2'd0; bus.cmsrc = 3'd0;
    bus.cal = 1'b0; bus.ret = 1'b0; bus.pop = 1'b0; bus.push = 1'b0; bus.ambain = 8'h00;
  endtask

  // Called at posedge+1 with inputs already driven: check combinational outputs, clock, check state.
  task automatic step(input string tag);
    #2;
    check({tag, ".dataout"}, bus.dataout, m_reg[bus.Addr]);
    check({tag, ".muxout"}, bus.muxout, m_mux());
    check({tag, ".CEE"}, bus.CEE, m_reg[0] ^ bus.Literal);
    check({tag, ".CEENZ"}, bus.CEENZ, m_reg[0] != bus.Literal);
    @(posedge clk);
    m_exec();
    #1;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    @(posedge clk);
    m_reset();
    #1;
    check_state(tag);
    check({tag, ".CEENZ"}, bus.CEENZ, bus.Literal != 8'h00);
    rst = 1'b1;
  endtask

  logic [7:0] p;

  initial begin
    rst = 1'b1;
    nop();
    @(posedge clk);
    #1;

    // Reset
    bus.Literal = 8'h5A;
    do_reset("reset");
    check("reset.R0_const", bus.R0, 8'h00);
    check("reset.PC_const", bus.PC, 8'h00);

    // IN R1; LOAD R2; ADD into R0
    nop(); bus.datain = 8'h11; bus.Addr = 6'd1; bus.wr_en = 1'b1; bus.cpc = 2'd1; bus.csrc = 2'd0;
    step("in_r1");
    nop(); bus.Literal = 8'h2B; bus.Addr = 6'd2; bus.wr_en = 1'b1; bus.cpc = 2'd1; bus.csrc = 2'd1;
    step("ld_r2");
    nop(); bus.calu = 6'd1; bus.Addr = 6'd0; bus.wr_en = 1'b1; bus.cpc = 2'd1; bus.csrc = 2'd3;
    step("add");
    check("add.R0_const", bus.R0, 8'h3C);
    check("add.PC_const", bus.PC, 8'h03);

    // Compare-skip
    nop(); bus.cpc = 2'd2; bus.Literal = 8'h3C;
    #1 check("cmp_eq.CEENZ_const", bus.CEENZ, 1'b0);
    step("cmp_eq");
    check("cmp_eq.PC_const", bus.PC, 8'h04);
    nop(); bus.cpc = 2'd2; bus.Literal = 8'h30;
    #1 check("cmp_ne.CEE_const", bus.CEE, 8'h0C);
    step("cmp_ne");
    check("cmp_ne.PC_const", bus.PC, 8'h06);

    // Push / IN / Pop
    nop(); bus.push = 1'b1; bus.Addr = 6'd0;
    step("push");
    check("push.stack_const", bus.stack, 8'h3C);
    nop(); bus.datain = 8'h11; bus.Addr = 6'd0; bus.wr_en = 1'b1; bus.cpc = 2'd1;
    step("in_r0");
    nop(); bus.pop = 1'b1; bus.Addr = 6'd0; bus.wr_en = 1'b1; bus.cmsrc = 3'd7; bus.cpc = 2'd1;
    step("pop");
    check("pop.R0_const", bus.R0, 8'h3C);
    check("pop.stack_const", bus.stack, 8'h00);

    // Jump / call / return
    nop(); bus.cpc = 2'd0; bus.Literal = 8'hA2; bus.wr_en = 1'b1; bus.Addr = 6'd5;
    step("jmp");
    check("jmp.PC_const", bus.PC, 8'hA2);
    p = bus.PC;
    nop(); bus.cal = 1'b1; bus.Literal = 8'd170; bus.cpc = 2'd1;
    step("call");
    check("call.PC_const", bus.PC, 8'hAA);
    check("call.LNK_const", bus.LNK, p + 8'd1);
    nop(); bus.Literal = 8'h66; bus.Addr = 6'd3; bus.wr_en = 1'b1; bus.csrc = 2'd1; bus.cpc = 2'd1;
    step("ld_r3");
    check("ld_r3.R3_const", bus.R3, 8'h66);
    for (int k = 0; k < 2; k++) begin
      nop(); bus.ret = 1'b1;
      step("ret");
      check("ret.PC_const", bus.PC, p + 8'd1);
    end
    nop(); bus.cpc = 2'd0; bus.Literal = 8'h00;
    step("jmp0");

    // Interrupt with a pending LOAD
    nop(); bus.Literal = 8'h77; bus.Addr = 6'd4; bus.wr_en = 1'b1; bus.csrc = 2'd1; bus.cpc = 2'd1;
    bus.eint = 1'b1; bus.ambain = 8'h33;
    p = bus.PC;
    step("irq");
    check("irq.PC_const", bus.PC, 8'h33);
    check("irq.LNK_const", bus.LNK, p + 8'd1);
    check("irq.R4_const", bus.R4, 8'h00);

    // PC wrap
    nop(); bus.cpc = 2'd0; bus.Literal = 8'hFF;
    step("jmp_ff");
    nop(); bus.cpc = 2'd1;
    step("wrap");
    check("wrap.PC_const", bus.PC, 8'h00);

    // Stack overflow: nine pushes of 1..9, the ninth is dropped
    for (int k = 1; k <= 9; k++) begin
      nop(); bus.Literal = 8'(k); bus.Addr = 6'd5; bus.wr_en = 1'b1; bus.csrc = 2'd1; bus.cpc = 2'd1;
      step("ovf_ld");
      nop(); bus.push = 1'b1; bus.Addr = 6'd5;
      step("ovf_push");
    end
    check("ovf.stack_const", bus.stack, 8'h08);
    // Simultaneous push and pop behaves as a pop
    nop(); bus.push = 1'b1; bus.pop = 1'b1; bus.Addr = 6'd6;
    step("pushpop");
    check("pushpop.stack_const", bus.stack, 8'h07);
    for (int k = 0; k < 9; k++) begin
      nop(); bus.pop = 1'b1; bus.Addr = 6'd6; bus.wr_en = 1'b1; bus.cpc = 2'($urandom_range(0, 3));
      step("drain");
    end
    check("drain.R6_const", bus.R6, 8'h00);

    // Random control words
    for (int n = 0; n < 400; n++) begin
      int kind;
      nop();
      bus.Literal = 8'($urandom);
      bus.Addr    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      bus.datain  = 8'($urandom);
      bus.wr_en   = 1'($urandom);
      bus.calu    = 6'($urandom_range(0, 10));
      bus.cpc     = 2'($urandom);
      bus.csrc    = 2'($urandom);
      bus.cmsrc   = 3'($urandom);
      bus.ambain  = 8'($urandom);
      kind = $urandom_range(0, 39);
      if (kind == 0) begin
        do_reset("rnd_reset");
      end else begin
        case (kind)
          1, 2, 3, 4: bus.push = 1'b1;
          5, 6, 7:    bus.pop  = 1'b1;
          8:          bus.cal  = 1'b1;
          9:          bus.ret  = 1'b1;
          10: begin
            bus.eint = 1'b1;
            bus.cal  = 1'($urandom);
            bus.push = 1'($urandom);
          end
          default: ;
        endcase
        step("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
